// File: rtl/uart_pkg.sv
// Shared definitions for the UART RX pack controller: state encoding,
// FIFO read-phase code and default buffer placement.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_FULL    = 2'd3
    } uart_state_e;

    localparam logic [1:0]  UART_RD_PHASE = 2'b10;
    localparam logic [31:0] UART_BUF_BASE = 32'h0000_0400;

    function automatic logic [31:0] buf_word_addr(input logic [31:0] base,
                                                  input logic [8:0]  ptr);
        return base + {21'd0, ptr, 2'b00};
    endfunction

endpackage

// File: rtl/uart_byte_packer.sv
// Little-endian byte-to-word packer: each push lands in the next lane and
// sets its byte enable; clear empties the word after it has been written.
module uart_byte_packer
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [7:0]  byte_in,
    input  logic        clear,
    output logic [31:0] word,
    output logic [3:0]  be,
    output logic [2:0]  byte_cnt
);

    logic [31:0] word_q, word_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        be_d   = be_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = '0;
            be_d   = '0;
            cnt_d  = '0;
        end else if (push && !cnt_q[2]) begin
            word_d[{cnt_q[1:0], 3'b000} +: 8] = byte_in;
            be_d[cnt_q[1:0]]                  = 1'b1;
            cnt_d                             = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q <= '0;
            be_q   <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            be_q   <= be_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word     = word_q;
    assign be       = be_q;
    assign byte_cnt = cnt_q;

endmodule

// File: rtl/uart_rx_pack_ctrl.sv
// Drains the UART RX FIFO, packs bytes into 32-bit words and writes them to a
// linear buffer in data memory over a req/gnt port; irq pulses when it fills.
//
// state   | meaning
// IDLE    | nothing buffered, waiting for FIFO data
// COLLECT | popping bytes into the packer on read phases
// WRITE   | word presented on mem port, waiting for grant
// FULL    | buffer full, waiting for buf_ack
module uart_rx_pack_ctrl
    import uart_pkg::*;
#(
    parameter logic [31:0] BUF_BASE  = UART_BUF_BASE,
    parameter int          BUF_WORDS = 16,
    parameter int          TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        buf_ack,
    input  logic [1:0]  data_clk,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_rd_data,
    output logic        fifo_rd_en,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic [7:0]  word_ptr,
    output logic        buf_full,
    output logic        irq
);

    localparam int             TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [8:0]     WORDS_W  = 9'(BUF_WORDS);

    uart_state_e    state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    // One bit wider than word_ptr so a 256-word buffer can still reach "full".
    logic [8:0]     wptr_q, wptr_d;
    logic           mem_req_q, mem_req_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic           buf_full_q, buf_full_d;
    logic           irq_q, irq_d;
    logic [2:0]     byte_cnt;
    logic           grant;

    assign fifo_rd_en = reset && (state_q == ST_COLLECT) && enable && !fifo_empty
                        && (data_clk == UART_RD_PHASE);
    assign grant      = (state_q == ST_WRITE) && mem_gnt;

    uart_byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_rd_en),
        .byte_in  (fifo_rd_data[7:0]),
        .clear    (grant),
        .word     (mem_wdata),
        .be       (mem_be),
        .byte_cnt (byte_cnt)
    );

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        wptr_d  = wptr_q;
        case (state_q)
            ST_IDLE: begin
                if (buf_ack) wptr_d = '0;
                if (enable && !fifo_empty) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (buf_ack) wptr_d = '0;
                if (fifo_rd_en) begin
                    if (byte_cnt == 3'd3) state_d = ST_WRITE;
                end else if (byte_cnt != 3'd0) begin
                    if (!enable || timer_q == TMO_LAST) state_d = ST_WRITE;
                    else if (timer_q != '1)             timer_d = timer_q + TW'(1);
                    else                                timer_d = timer_q;
                end else if (fifo_empty || !enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (mem_gnt) begin
                    wptr_d = wptr_q + 9'd1;
                    if (wptr_d == WORDS_W)          state_d = ST_FULL;
                    else if (enable && !fifo_empty) state_d = ST_COLLECT;
                    else                            state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (buf_ack) begin
                    wptr_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        mem_req_d  = (state_d == ST_WRITE);
        mem_addr_d = (state_d == ST_WRITE) ? buf_word_addr(BUF_BASE, wptr_d) : '0;
        buf_full_d = (state_d == ST_FULL);
        irq_d      = (state_d == ST_FULL) && (state_q != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            wptr_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            buf_full_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            wptr_q     <= wptr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            buf_full_q <= buf_full_d;
            irq_q      <= irq_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign word_ptr = wptr_q[7:0];
    assign buf_full = buf_full_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_pack_ctrl.sv
// Scoreboard bench for uart_rx_pack_ctrl: a FIFO model feeds bytes, expected
// words are queued when bytes are pushed and compared on each granted write.
module tb_uart_rx_pack_ctrl;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset, enable, buf_ack, fifo_empty, fifo_rd_en;
    logic        mem_req, mem_gnt, buf_full, irq;
    logic [1:0]  data_clk;
    logic [31:0] fifo_rd_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [7:0]  word_ptr;

    always #5 clk = ~clk;

    uart_rx_pack_ctrl #(.BUF_BASE(32'h0000_0400), .BUF_WORDS(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .enable(enable), .buf_ack(buf_ack),
        .data_clk(data_clk), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .word_ptr(word_ptr), .buf_full(buf_full), .irq(irq)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic [7:0]  fifo_q[$];
    wr_t         exp_q[$];
    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          last_pop_edge = 0, req_rise_edge = 0, irq_cnt = 0, tb_wptr = 0;
    bit          pop_pend, cycling = 1'b0, req_prev = 1'b0, hold_prev = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;
    logic [3:0]  prev_be = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic refresh_fifo();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = fifo_empty ? 32'h0 : {24'hDEAD5A, fifo_q[0]};
    endtask

    // One clock: monitor at negedge, FIFO model and input updates just after posedge.
    task automatic step();
        wr_t e;
        @(negedge clk);
        pop_pend = fifo_rd_en;
        if (fifo_rd_en) begin
            chk("rd_phase", 32'(data_clk), 32'(UART_RD_PHASE));
            last_pop_edge = cyc + 1;
        end
        if (mem_req) chk("rd_in_write", 32'(fifo_rd_en), 0);
        if (mem_req && hold_prev) begin
            chk("hold_addr", mem_addr, prev_addr);
            chk("hold_data", mem_wdata, prev_data);
            chk("hold_be", 32'(mem_be), 32'(prev_be));
        end
        if (mem_req && !req_prev) req_rise_edge = cyc;
        if (irq) irq_cnt++;
        if (mem_req && mem_gnt) begin
            chk("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
                chk("wr_be", 32'(mem_be), 32'(e.be));
            end
        end
        hold_prev = mem_req && !mem_gnt;
        req_prev  = mem_req;
        prev_addr = mem_addr;
        prev_data = mem_wdata;
        prev_be   = mem_be;
        @(posedge clk);
        #1;
        cyc++;
        if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (cycling) data_clk = data_clk + 2'd1;
        refresh_fifo();
    endtask

    task automatic push_word(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(w[i*8 +: 8]);
        refresh_fifo();
    endtask

    task automatic expect_word(input logic [31:0] w, input int n);
        wr_t e;
        logic [31:0] m;
        m = '0;
        e.be = '0;
        for (int i = 0; i < n; i++) begin
            m[i*8 +: 8] = 8'hFF;
            e.be[i] = 1'b1;
        end
        e.addr = 32'h0000_0400 + 32'(4 * tb_wptr);
        e.data = w & m;
        exp_q.push_back(e);
        tb_wptr++;
    endtask

    task automatic feed_word(input logic [31:0] w, input int n);
        push_word(w, n);
        expect_word(w, n);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin step(); n++; end
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!mem_req && n < budget) begin step(); n++; end
        chk("req_seen", 32'(mem_req), 1);
    endtask

    task automatic wait_fifo_empty(input int budget);
        int n = 0;
        while (fifo_q.size() != 0 && n < budget) begin step(); n++; end
        chk("fifo_drained", 32'(fifo_q.size()), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_be"}, 32'(mem_be), 0);
        chk({tag, "_wptr"}, 32'(word_ptr), 0);
        chk({tag, "_full"}, 32'(buf_full), 0);
        chk({tag, "_irq"}, 32'(irq), 0);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; buf_ack = 1'b0; mem_gnt = 1'b0;
        cycling = 1'b0; data_clk = 2'b10;
        fifo_q.delete();
        exp_q.delete();
        refresh_fifo();
        step();
        step();
        reset = 1'b1;
        tb_wptr = 0;
        irq_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; buf_ack = 1'b0; mem_gnt = 1'b0; data_clk = 2'b10;
        refresh_fifo();
        step();
        step();
        check_zero("rst");
        reset = 1'b1;

        // Full word, immediate grant
        mem_gnt = 1'b1; enable = 1'b1;
        feed_word(32'h4433_2211, 4);
        wait_drain(40);
        chk("t1_wptr", 32'(word_ptr), 1);

        // Single byte flushed by the idle timeout
        do_reset();
        mem_gnt = 1'b1; enable = 1'b1;
        feed_word(32'h0000_00A5, 1);
        wait_drain(200);
        chk("t2_timeout_lat", 32'(req_rise_edge - last_pop_edge), 64);

        // Grant held off for 10 cycles with more data waiting in the FIFO
        do_reset();
        mem_gnt = 1'b0; enable = 1'b1;
        feed_word(32'hDDCC_BBAA, 4);
        feed_word(32'h8877_6655, 4);
        wait_req(40);
        for (int i = 0; i < 10; i++) step();
        chk("t3_req_held", 32'(mem_req), 1);
        chk("t3_no_pop", 32'(fifo_q.size()), 4);
        mem_gnt = 1'b1;
        step();
        chk("t3_req_drop", 32'(mem_req), 0);
        wait_drain(40);

        // Two-word buffer fills, irq pulses once, ack rewinds
        do_reset();
        mem_gnt = 1'b1; enable = 1'b1;
        feed_word(32'h0403_0201, 4);
        feed_word(32'h0807_0605, 4);
        wait_drain(60);
        push_word(32'h0C0B_0A09, 4);
        for (int i = 0; i < 20; i++) step();
        chk("t4_full", 32'(buf_full), 1);
        chk("t4_irq_pulses", 32'(irq_cnt), 1);
        chk("t4_wptr", 32'(word_ptr), 2);
        chk("t4_no_pop", 32'(fifo_q.size()), 4);
        buf_ack = 1'b1;
        step();
        buf_ack = 1'b0;
        chk("t4_ack_wptr", 32'(word_ptr), 0);
        chk("t4_ack_full", 32'(buf_full), 0);
        tb_wptr = 0;
        expect_word(32'h0C0B_0A09, 4);
        wait_drain(40);
        chk("t4_wptr_after", 32'(word_ptr), 1);

        // Pops only on the read phase while data_clk cycles
        do_reset();
        mem_gnt = 1'b1; enable = 1'b1;
        data_clk = 2'b00; cycling = 1'b1;
        feed_word(32'hB3B2_B1B0, 4);
        wait_drain(60);
        cycling = 1'b0; data_clk = 2'b10;
        chk("t5_wptr", 32'(word_ptr), 1);

        // Enable drop flushes a partial word on the next edge
        do_reset();
        mem_gnt = 1'b1; enable = 1'b1;
        feed_word(32'h0000_BBAA, 2);
        wait_fifo_empty(20);
        enable = 1'b0;
        wait_drain(20);
        chk("t7_flush_lat", 32'(req_rise_edge - last_pop_edge), 1);

        // Reset mid-packing and mid-request drops everything
        do_reset();
        mem_gnt = 1'b0; enable = 1'b1;
        push_word(32'h0000_C2C1, 2);
        wait_fifo_empty(20);
        step();
        reset = 1'b0;
        step();
        check_zero("t6_pack");
        reset = 1'b1;
        push_word(32'hE4E3_E2E1, 4);
        wait_req(40);
        step();
        reset = 1'b0;
        step();
        check_zero("t6_req");
        reset = 1'b1;
        tb_wptr = 0;
        mem_gnt = 1'b1;
        feed_word(32'hD4D3_D2D1, 4);
        wait_drain(40);
        chk("t6_wptr", 32'(word_ptr), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
